mem_arbiter: RTL

- Arbitrates a single shared memory port between the instruction-fetch requester and the load/store (data) requester of the RV32I core.
- Sits between the core and the memory bus. Only one transaction is outstanding at a time.
- Data normally has priority. A starvation counter forces a fetch grant after a bounded number of losses.
- Returns read data and a completion pulse to whichever requester owns the current transaction.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch and load/store requesters of the core.
// Data wins by default; a starvation counter forces a fetch grant after MAX_WAIT losses.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nreset,
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_W-1:0]     o_if_rdata,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_W-1:0]     i_d_addr,
  input  logic [DATA_W-1:0]     i_d_wdata,
  input  logic [DATA_W/8-1:0]   i_d_wstrb,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_W-1:0]     o_d_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int          STRB_W     = DATA_W / 8;
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic grant_if, grant_d;

  // Fetch wins when alone, or when it has lost MAX_WAIT arbitrations in a row.
  assign grant_if = (state_q == IDLE) && i_if_req &&
                    (!i_d_req || (wait_cnt_q >= MAX_WAIT_C));
  assign grant_d  = (state_q == IDLE) && i_d_req && !grant_if;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = BUSY_IF;
          wait_cnt_d  = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          if_gnt_d    = 1'b1;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = i_d_we;
          mem_addr_d  = i_d_addr;
          mem_wdata_d = i_d_wdata;
          mem_wstrb_d = i_d_we ? i_d_wstrb : '0;
          d_gnt_d     = 1'b1;
          if (i_if_req && wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      BUSY_IF: begin
        if (i_mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = i_mem_rdata;
        end
      end
      BUSY_D: begin
        if (i_mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_we_q ? '0 : i_mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign o_if_gnt    = if_gnt_q;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_gnt     = d_gnt_q;
  assign o_d_rvalid  = d_rvalid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;

endmodule
